// File: rtl/data_mem_ctrl.sv
// Word-organised big-endian data memory with a valid/ready request/response port.
// Self-initialises every word to INIT_WORD after reset; byte/half/word loads and stores.
module data_mem_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        init_busy
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;

  state_t              state;
  logic [WORD_W-1:0]   cnt;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic [WORD_W-1:0]   word_idx;
  logic [1:0]          offset;
  logic                req_error;
  logic [3:0]          lane_en;
  logic [31:0]         wdata_rep;
  logic [31:0]         rd_word;
  logic [4:0]          byte_sh;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_val;
  logic [31:0]         rdata_next;

  // A new request may enter whenever the response slot is empty or being drained this cycle.
  assign req_ready = (state != INIT) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[ADDR_W-1:2];
  assign offset    = req_addr[1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_error = 1'b0;
    lane_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b01: begin
        lane_en   = 4'b1000 >> offset;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b10: begin
        req_error = offset[0];
        lane_en   = 4'b1100 >> offset;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b11: begin
        req_error = |offset;
        lane_en   = 4'b1111;
      end
      default: req_error = 1'b1;
    endcase
    if (|req_addr[31:ADDR_W]) req_error = 1'b1;
  end

  // Big-endian: offset 0 lives in bits [31:24], so the byte shift is (3 - offset) * 8.
  assign rd_word = mem[word_idx];
  assign byte_sh = {~offset, 3'b000};
  assign rd_byte = rd_word[byte_sh +: 8];
  assign rd_half = offset[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    case (req_size)
      2'b01:   load_val = req_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'b10:   load_val = req_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: load_val = rd_word;
    endcase
    rdata_next = (req_write || req_error) ? 32'h0 : load_val;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == WORD_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN, HOLD: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_next;
            rsp_error <= req_error;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
          state <= (rsp_valid && !rsp_ready) ? HOLD : RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: storage has no reset; INIT sweeps every word, so contents are defined once it ends.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      mem[cnt] <= INIT_WORD;
    end else if (!reset && accept && req_write && !req_error) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule
